pulse_window_counter: RTL and testbench
=======================================

// Module: pulse_window_counter
// PURPOSE
//  Sits directly downstream of the fast->slow pulse synchroniser, in the clk_slow domain.
//  Counts the single-cycle pulses it delivers over back-to-back windows of programmable length.
//  Pushes each completed window count into a small FIFO, read out over a valid/ready handshake.
//  Completed counts that find the FIFO full are dropped and tallied.
// PARAMETERS
//  CNT_W       8   width of per-window pulse count (saturating)
//  WIN_W       16  width of window-length input
//  FIFO_DEPTH  4   result FIFO entries; power of 2, >=2
// PORTS
//  clk_slow   in   1                        single clock, all logic on rising edge
//  rst        in   1                        asynchronous, active-high reset
//  pulse_in   in   1                        1-cycle event pulse from synchroniser
//  enable     in   1                        1 = run windows; 0 = idle, partial window discarded
//  win_len    in   WIN_W                    window length in cycles; 0 treated as 1
//  cnt_data   out  CNT_W                    count at FIFO head
//  cnt_valid  out  1                        FIFO non-empty
//  cnt_ready  in   1                        consumer accepts head when cnt_valid&cnt_ready
//  drop_cnt   out  8                        dropped-window counter, saturates at 255
//  fifo_level out  $clog2(FIFO_DEPTH)+1     current FIFO occupancy
// BEHAVIOUR
//  Reset (async assert, sync release):
//   - state=IDLE; FIFO emptied.
//   - cnt_valid=0, cnt_data=0, drop_cnt=0, fifo_level=0.
//  FSM:
//   - IDLE->COUNT on cycle enable=1: win_len sampled (0->1), timer=len, acc=0.
//   - COUNT->IDLE on any cycle enable=0: acc discarded, no push.
//   - COUNT, timer==1 (last cycle): push final count; reload timer from win_len
//     (new value), acc=0; stay in COUNT.
//  Counting:
//   - Each COUNT cycle with pulse_in=1 adds 1 to acc.
//   - acc saturates at 2^CNT_W-1.
//   - Value pushed = acc including a pulse on the last cycle.
//   - pulse_in ignored in IDLE.
//   - pulse_in held high N cycles counts N.
//  Timing:
//   - Window of L cycles spans L consecutive COUNT cycles.
//   - Push registered at edge ending last cycle; cnt_valid=1 from next cycle (latency 1).
//  FIFO / handshake:
//   - Head pops on a cycle with cnt_valid&cnt_ready.
//   - cnt_data stable while cnt_valid&!cnt_ready.
//   - Order is FIFO.
//   - Simultaneous push+pop: accepted even when full (level unchanged).
//   - Push when full and no pop: count dropped, drop_cnt+1 (sat 255), FIFO contents untouched.
//   - cnt_ready while empty: no effect.
//   - cnt_data holds last popped value when empty (don't-care to consumer).
//  Reset mid-window or with FIFO non-empty: all state cleared immediately, outputs
//  as above; after release, first window begins on first enable=1 cycle.
// TESTING
//  T1 win_len=10, ready=1, pulses at window cycles 2,5,9 -> one entry 3; cnt_valid=1 one cycle after cycle 10.
//  T2 CNT_W=4, win_len=32, 20 pulses -> cnt_data=15 (saturated), next window starts at 0.
//  T3 ready=0, win_len=4, 1 pulse/window x5 -> level=4, drop_cnt=1; ready=1 drains 1,1,1,1 then valid=0.
//  T4 enable drops at cycle 5 of 10 with 2 pulses counted -> no push; re-enable gives fresh window count.
//  T5 pulse on last window cycle and on first cycle of next -> consecutive entries 1 and 1.
//  T6 FIFO full, push and pop same cycle -> no drop, level stays 4; rst pulse mid-window -> valid=0, level=0 at once.

Source files
------------

// File: rtl/pulse_window_counter_if.sv
// Result stream from pulse_window_counter to its consumer.
interface pulse_window_counter_if #(
  parameter int CNT_W = 8
);
  // A word moves on every rising edge where cnt_valid && cnt_ready; while cnt_valid is
  // high and cnt_ready low, cnt_data holds. cnt_ready with cnt_valid low does nothing.
  logic [CNT_W-1:0] cnt_data;
  logic             cnt_valid;
  logic             cnt_ready;

  modport master (
    output cnt_data,
    output cnt_valid,
    input  cnt_ready
  );

  modport slave (
    input  cnt_data,
    input  cnt_valid,
    output cnt_ready
  );
endinterface

// File: rtl/pulse_window_counter.sv
// Counts synchronised pulses over back-to-back programmable windows and queues each
// window's saturated count in a small FIFO; counts arriving at a full FIFO are tallied.
module pulse_window_counter #(
  parameter int CNT_W      = 8,
  parameter int WIN_W      = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk_slow,
  input  logic                          rst,
  input  logic                          pulse_in,
  input  logic                          enable,
  input  logic [WIN_W-1:0]              win_len,
  pulse_window_counter_if.master        cnt_if,
  output logic [7:0]                    drop_cnt,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          dbg_state
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int LVL_W = AW + 1;
  localparam logic [CNT_W-1:0] ACC_MAX = '1;

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIN_W-1:0] timer_q, timer_d;
  logic [WIN_W-1:0] len_eff;
  logic [CNT_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] acc_inc;
  logic             push;

  logic [CNT_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]    rd_ptr, wr_ptr;
  logic [LVL_W-1:0] level;
  logic [CNT_W-1:0] last_q;
  logic             full, empty, pop, accept, drop;

  assign len_eff = (win_len == '0) ? WIN_W'(1) : win_len;
  // The current cycle's pulse is folded in here so a pulse on the last cycle is pushed.
  assign acc_inc = (pulse_in && (acc_q != ACC_MAX)) ? acc_q + CNT_W'(1) : acc_q;

  always_ff @(posedge clk_slow or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      timer_q <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      acc_q   <= acc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    acc_d   = acc_q;
    push    = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable) begin
          state_d = COUNT;
          timer_d = len_eff;
          acc_d   = '0;
        end
      end
      COUNT: begin
        if (!enable) begin
          state_d = IDLE;
          acc_d   = '0;
        end else if (timer_q == WIN_W'(1)) begin
          push    = 1'b1;
          timer_d = len_eff;
          acc_d   = '0;
        end else begin
          timer_d = timer_q - WIN_W'(1);
          acc_d   = acc_inc;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign full   = (level == LVL_W'(FIFO_DEPTH));
  assign empty  = (level == '0);
  assign pop    = !empty && cnt_if.cnt_ready;
  // When full, a simultaneous pop frees the slot the push lands in.
  assign accept = push && (!full || pop);
  assign drop   = push && full && !pop;

  always_ff @(posedge clk_slow or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      level    <= '0;
      last_q   <= '0;
      drop_cnt <= '0;
    end else begin
      if (accept) begin
        mem[wr_ptr] <= acc_inc;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) begin
        last_q <= mem[rd_ptr];
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({accept, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
      if (drop && (drop_cnt != 8'hFF)) drop_cnt <= drop_cnt + 8'd1;
    end
  end

  assign cnt_if.cnt_valid = !empty;
  assign cnt_if.cnt_data  = empty ? last_q : mem[rd_ptr];
  assign fifo_level       = level;
  assign dbg_state        = state_q;

endmodule

// File: tb/tb_pulse_window_counter.sv
// Directed scenarios plus randomized traffic, checked every cycle against a window/queue model.
module tb_pulse_window_counter;

  localparam int CNT_W = 4;
  localparam int DEPTH = 4;
  localparam int MAXC  = (1 << CNT_W) - 1;

  logic        clk_slow;
  logic        rst;
  logic        pulse_in;
  logic        enable;
  logic [15:0] win_len;
  logic [7:0]  drop_cnt;
  logic [2:0]  fifo_level;
  logic        dbg_state;

  pulse_window_counter_if #(.CNT_W(CNT_W)) cnt_if ();

  pulse_window_counter #(
    .CNT_W(CNT_W), .WIN_W(16), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk_slow  (clk_slow),
    .rst       (rst),
    .pulse_in  (pulse_in),
    .enable    (enable),
    .win_len   (win_len),
    .cnt_if    (cnt_if),
    .drop_cnt  (drop_cnt),
    .fifo_level(fifo_level),
    .dbg_state (dbg_state)
  );

  initial clk_slow = 1'b0;
  always #5 clk_slow = ~clk_slow;

  int total = 0;
  int bad   = 0;

  // Reference model: window in progress, raw pulse tally, queue of completed counts.
  int q[$];
  int m_drop, m_last, m_len, m_pos, m_pulses;
  bit m_run;

  task automatic model_reset();
    q.delete();
    m_drop = 0; m_last = 0; m_run = 0;
    m_len = 1; m_pos = 0; m_pulses = 0;
  endtask

  task automatic model_edge(input bit p, input bit e, input int len, input bit r);
    bit pop;
    bit push;
    int val;
    pop  = (q.size() > 0) && r;
    push = 0;
    val  = 0;
    if (!m_run) begin
      if (e) begin
        m_run = 1; m_pos = 0; m_pulses = 0;
        m_len = (len == 0) ? 1 : len;
      end
    end else if (!e) begin
      m_run = 0;
    end else begin
      m_pulses += p;
      m_pos++;
      if (m_pos == m_len) begin
        push = 1;
        val  = (m_pulses > MAXC) ? MAXC : m_pulses;
        m_pos = 0; m_pulses = 0;
        m_len = (len == 0) ? 1 : len;
      end
    end
    if (pop) m_last = q.pop_front();
    if (push) begin
      if (q.size() < DEPTH) q.push_back(val);
      else if (m_drop < 255) m_drop++;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("valid", cnt_if.cnt_valid, (q.size() > 0));
    check("level", fifo_level, q.size());
    check("drop",  drop_cnt, m_drop);
    check("data",  cnt_if.cnt_data, (q.size() > 0) ? q[0] : m_last);
    check("state", dbg_state, m_run);
  endtask

  task automatic step(input bit p, input bit e, input int len, input bit r);
    pulse_in         = p;
    enable           = e;
    win_len          = len[15:0];
    cnt_if.cnt_ready = r;
    @(posedge clk_slow);
    #1;
    model_edge(p, e, len, r);
    check_all();
  endtask

  // Asserts reset between edges so the clear is seen without any clock edge.
  task automatic do_reset();
    pulse_in = 0; enable = 0; cnt_if.cnt_ready = 0;
    #1;
    rst = 1;
    #1;
    model_reset();
    check_all();
    check("rst_valid", cnt_if.cnt_valid, 0);
    check("rst_level", fifo_level, 0);
    @(negedge clk_slow);
    rst = 0;
  endtask

  initial begin
    rst = 1; pulse_in = 0; enable = 0; win_len = 16'd0; cnt_if.cnt_ready = 0;
    model_reset();
    #1;
    check_all();
    check("reset_data", cnt_if.cnt_data, 0);
    check("reset_drop", drop_cnt, 0);
    @(negedge clk_slow);
    rst = 0;

    // T1: 10-cycle window, pulses on cycles 2, 5, 9.
    step(0, 1, 10, 1);
    for (int k = 1; k <= 10; k++) step(k == 2 || k == 5 || k == 9, 1, 10, 1);
    check("t1_valid", cnt_if.cnt_valid, 1);
    check("t1_data", cnt_if.cnt_data, 3);
    step(0, 0, 10, 1);
    check("t1_empty", cnt_if.cnt_valid, 0);

    // T2: 20 pulses in a 32-cycle window saturate a 4-bit count; next window restarts at 0.
    do_reset();
    step(0, 1, 32, 0);
    for (int k = 1; k <= 32; k++) step(k <= 20, 1, 32, 0);
    check("t2_sat", cnt_if.cnt_data, 15);
    for (int k = 1; k <= 32; k++) step(0, 1, 32, 0);
    check("t2_level", fifo_level, 2);
    step(0, 0, 32, 1);
    check("t2_next", cnt_if.cnt_data, 0);
    step(0, 0, 32, 1);

    // T3: five one-pulse windows with the consumer stalled.
    do_reset();
    step(0, 1, 4, 0);
    for (int k = 0; k < 20; k++) step(k % 4 == 0, 1, 4, 0);
    check("t3_level", fifo_level, 4);
    check("t3_drop", drop_cnt, 1);
    for (int k = 0; k < 4; k++) begin
      check("t3_head", cnt_if.cnt_data, 1);
      step(0, 0, 4, 1);
    end
    check("t3_drained", cnt_if.cnt_valid, 0);

    // T4: enable drops mid-window; the partial count is discarded.
    do_reset();
    step(0, 1, 10, 1);
    for (int k = 1; k <= 4; k++) step(k == 1 || k == 3, 1, 10, 1);
    step(0, 0, 10, 1);
    check("t4_nopush", fifo_level, 0);
    step(0, 1, 10, 1);
    for (int k = 1; k <= 10; k++) step(k == 7, 1, 10, 1);
    check("t4_fresh", cnt_if.cnt_data, 1);
    step(0, 0, 10, 1);

    // T5: pulses straddling a window boundary land in separate entries.
    do_reset();
    step(0, 1, 3, 0);
    for (int k = 1; k <= 6; k++) step(k == 3 || k == 4, 1, 3, 0);
    check("t5_level", fifo_level, 2);
    check("t5_first", cnt_if.cnt_data, 1);
    step(0, 0, 3, 1);
    check("t5_second", cnt_if.cnt_data, 1);
    step(0, 0, 3, 1);

    // T6: push and pop together while full, then reset in the middle of a window.
    do_reset();
    step(0, 1, 1, 0);
    for (int k = 0; k < 4; k++) step(1, 1, 1, 0);
    check("t6_full", fifo_level, 4);
    step(0, 1, 1, 1);
    check("t6_pushpop_level", fifo_level, 4);
    check("t6_pushpop_drop", drop_cnt, 0);
    step(1, 1, 5, 0);
    check("t6_drop", drop_cnt, 1);
    step(1, 1, 5, 0);
    do_reset();
    check("t6_rst_drop", drop_cnt, 0);

    // Randomized traffic with occasional resets.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 499) == 0) do_reset();
      step($urandom_range(0, 3) != 0, $urandom_range(0, 19) != 0,
           ($urandom_range(0, 3) == 0) ? $urandom_range(0, 24) : $urandom_range(0, 5),
           $urandom_range(0, 2) != 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
